// File: rtl/lab_pkg.sv
// -----------------------------------------------------------------------------
// lab_pkg -- shared definitions for the digit_scanner display driver.
//
// Contents:
//   state_t        two-state scanner FSM encoding (IDLE = dark, SCAN = cycling)
//   DWELL_DEFAULT  default number of clock cycles each digit is held
//   BLANK_LIMIT    nibbles below this value are not displayable (decoder is A-F)
//   AN_OFF         all digit enables released (active-low)
//   nibble_sel     picks digit idx out of a packed 4-digit word
//   an_decode      one-hot-low digit enable for digit idx
// -----------------------------------------------------------------------------
package lab_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int         DWELL_DEFAULT = 1000;
  localparam logic [3:0] BLANK_LIMIT   = 4'hA;
  localparam logic [3:0] AN_OFF        = 4'b1111;

  // Digit k lives in bits [4k+3:4k].
  function automatic logic [3:0] nibble_sel(input logic [15:0] word,
                                            input logic [1:0]  idx);
    return word[4*idx +: 4];
  endfunction

  // Active-low enable: only bit idx is pulled low.
  function automatic logic [3:0] an_decode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter -- counts the cycles a digit stays on and flags the last one.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, forces count to 0
//   clr    synchronous clear, forces count to 0
//   en     count enable (high while scanning)
//   wrap   high in the cycle where count == DWELL-1 and en is set; the count
//          returns to 0 on the following edge
// -----------------------------------------------------------------------------
module dwell_counter
  import lab_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int             W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0]   LAST = W'(DWELL - 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign wrap = en && (count == LAST);

endmodule

// File: rtl/digit_scanner.sv
// -----------------------------------------------------------------------------
// digit_scanner -- time-multiplexes four hex digits onto a shared A-F segment
// decoder with double-buffered word loading.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, dominates everything
//   load       request to accept data_in (taken when ready=1 and clear=0)
//   data_in    four packed hex codes, digit 0 in [3:0]
//   clear      blank the display and stop scanning; beats load and transfer
//   ready      high when a load will be accepted this cycle
//   w,x,y,z    registered code of the selected digit, w is the MSB
//   an         registered active-low digit enables (one-hot-low or all high)
//
// A load goes into the shadow word. The shadow is promoted to the active word
// either immediately from IDLE or at the end of a full frame (digit 3 wrap),
// so a new word never appears part-way through a frame.
// -----------------------------------------------------------------------------
module digit_scanner
  import lab_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        clear,
  output logic        ready,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an
);

  state_t      state;
  logic [15:0] active;
  logic [15:0] shadow;
  logic        shadow_full;
  logic [1:0]  index;
  logic [3:0]  nib;
  logic        wrap;

  assign ready = ~shadow_full;
  assign nib   = nibble_sel(active, index);

  // The counter is held at 0 outside SCAN, which also gives the required
  // zero start when IDLE hands over to SCAN.
  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (clear || (state != SCAN)),
    .en    (state == SCAN),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data words are ordinary flops, not a memory, so clearing
      // them on reset is cheap and guarantees no stale digits survive.
      state          <= IDLE;
      active         <= '0;
      shadow         <= '0;
      shadow_full    <= 1'b0;
      index          <= '0;
      an             <= AN_OFF;
      {w, x, y, z}   <= 4'h0;
    end else if (clear) begin
      state          <= IDLE;
      shadow_full    <= 1'b0;
      index          <= '0;
      an             <= AN_OFF;
      {w, x, y, z}   <= 4'h0;
    end else begin
      // Outputs reflect the pre-edge digit, so an and the code always move
      // together one cycle after the index/active update.
      if (state == SCAN) begin
        {w, x, y, z} <= nib;
        an           <= (nib < BLANK_LIMIT) ? AN_OFF : an_decode(index);
      end else begin
        {w, x, y, z} <= 4'h0;
        an           <= AN_OFF;
      end

      case (state)
        IDLE: begin
          if (shadow_full) begin
            active      <= shadow;
            shadow_full <= 1'b0;
            index       <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (wrap) begin
            index <= index + 1'b1;
            // Frame boundary: swap in a pending word only after digit 3.
            if ((index == 2'd3) && shadow_full) begin
              active      <= shadow;
              shadow_full <= 1'b0;
            end
          end
        end
      endcase

      // Transfers above need shadow_full=1 and a load needs it 0, so these
      // two writes of shadow_full never collide.
      if (load && !shadow_full) begin
        shadow      <= data_in;
        shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// -----------------------------------------------------------------------------
// tb_digit_scanner -- directed bench for digit_scanner with DWELL=4.
// Inputs change and outputs are sampled on the falling edge. "Edge 0" in each
// scenario is the rising edge on which the first load is taken.
// -----------------------------------------------------------------------------
module tb_digit_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic        clear;
  logic        ready;
  logic        w, x, y, z;
  logic [3:0]  an;
  logic [3:0]  code;

  int tests_run = 0;
  int tests_failed = 0;

  assign code = {w, x, y, z};

  always #5 clk = ~clk;

  digit_scanner #(
    .DWELL (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .clear   (clear),
    .ready   (ready),
    .w       (w),
    .x       (x),
    .y       (y),
    .z       (z),
    .an      (an)
  );

  // One rising edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; clear = 1'b0; data_in = 16'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] d);
    load = 1'b1; data_in = d;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      tests_run++;
      if (an !== 4'b1111 || code !== 4'h0 || ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d an=%b code=%h ready=%b, want an=1111 code=0 ready=1",
                 k, an, code, ready);
      end
      step();
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an, exp_code;
    int d;
    do_reset();
    load_word(16'hFEDC);                       // edge 0
    tests_run++;
    if (ready !== 1'b0 || an !== 4'b1111) begin
      tests_failed++;
      $display("FAIL scan_e0 ready=%b an=%b, want ready=0 an=1111", ready, an);
    end
    step();                                    // edge 1
    tests_run++;
    if (ready !== 1'b1 || an !== 4'b1111) begin
      tests_failed++;
      $display("FAIL scan_e1 ready=%b an=%b, want ready=1 an=1111", ready, an);
    end
    for (int k = 2; k <= 33; k++) begin
      step();
      d        = ((k - 2) / 4) % 4;
      exp_code = 4'hC + 4'(d);
      exp_an   = 4'b1111 ^ (4'b0001 << d);
      tests_run++;
      if (an !== exp_an || code !== exp_code) begin
        tests_failed++;
        $display("FAIL scan_e%0d an=%b code=%h, want an=%b code=%h",
                 k, an, code, exp_an, exp_code);
      end
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_an, exp_code;
    int d;
    do_reset();
    load_word(16'hFEDC);                       // edge 0
    for (int k = 1; k <= 7; k++) step();
    load_word(16'hABCD);                       // edge 8, accepted mid-frame
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_e8 ready=%b, want 0", ready);
    end
    step();                                    // edge 9
    load_word(16'h1234);                       // edge 10, must be ignored
    for (int k = 10; k <= 16; k++) begin
      if (k > 10) step();
      tests_run++;
      if (ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reload_busy_e%0d ready=%b, want 0", k, ready);
      end
    end
    step();                                    // edge 17, frame boundary
    tests_run++;
    if (ready !== 1'b1 || an !== 4'b0111 || code !== 4'hF) begin
      tests_failed++;
      $display("FAIL reload_e17 ready=%b an=%b code=%h, want ready=1 an=0111 code=f",
               ready, an, code);
    end
    for (int k = 18; k <= 37; k++) begin
      step();
      d        = ((k - 18) / 4) % 4;
      exp_code = 4'hD - 4'(d);
      exp_an   = 4'b1111 ^ (4'b0001 << d);
      tests_run++;
      if (an !== exp_an || code !== exp_code) begin
        tests_failed++;
        $display("FAIL reload_e%0d an=%b code=%h, want an=%b code=%h",
                 k, an, code, exp_an, exp_code);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] codes [4];
    logic [3:0] exp_an;
    int d;
    codes[0] = 4'h9; codes[1] = 4'hB; codes[2] = 4'h3; codes[3] = 4'hA;
    do_reset();
    load_word(16'hA3B9);                       // edge 0
    step();                                    // edge 1
    for (int k = 2; k <= 17; k++) begin
      step();
      d      = (k - 2) / 4;
      exp_an = (codes[d] < 4'hA) ? 4'b1111 : (4'b1111 ^ (4'b0001 << d));
      tests_run++;
      if (an !== exp_an || code !== codes[d]) begin
        tests_failed++;
        $display("FAIL blank_e%0d an=%b code=%h, want an=%b code=%h",
                 k, an, code, exp_an, codes[d]);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    load_word(16'hFEDC);                       // edge 0
    for (int k = 1; k <= 7; k++) step();
    load_word(16'hABCD);                       // edge 8, shadow pending
    for (int k = 9; k <= 11; k++) step();
    clear = 1'b1; load = 1'b1; data_in = 16'h5555;
    step();                                    // edge 12
    clear = 1'b0; load = 1'b0;
    for (int k = 12; k <= 22; k++) begin
      if (k > 12) step();
      tests_run++;
      if (an !== 4'b1111 || code !== 4'h0 || ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL clear_e%0d an=%b code=%h ready=%b, want an=1111 code=0 ready=1",
                 k, an, code, ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(16'hFEDC);                       // edge 0
    for (int k = 1; k <= 7; k++) step();
    load_word(16'hABCD);                       // edge 8, shadow pending
    step();                                    // edge 9
    step();                                    // edge 10: digit 2 shown
    tests_run++;
    if (an !== 4'b1011 || code !== 4'hE) begin
      tests_failed++;
      $display("FAIL rmid_digit2 an=%b code=%h, want an=1011 code=e", an, code);
    end
    reset = 1'b1; clear = 1'b1; load = 1'b1; data_in = 16'h5555;
    step();                                    // edge 11
    reset = 1'b0; clear = 1'b0; load = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      tests_run++;
      if (an !== 4'b1111 || code !== 4'h0 || ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rmid_dark cyc=%0d an=%b code=%h ready=%b, want an=1111 code=0 ready=1",
                 k, an, code, ready);
      end
    end
    load_word(16'hFEDC);                       // new edge 0
    step();
    step();                                    // edge 2: restart at digit 0
    tests_run++;
    if (an !== 4'b1110 || code !== 4'hC) begin
      tests_failed++;
      $display("FAIL rmid_restart an=%b code=%h, want an=1110 code=c", an, code);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; clear = 1'b0; data_in = 16'h0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_reload();
    test_blank();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
